shift_register_multi_mode: RTL and testbench

//  Parametrised multi-mode shift register: DEPTH stages of DATA_W bits each.

---
 rtl/shift_register_multi_mode.sv | 105 ++++++++++
 tb/tb_shift_register_multi_mode.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_multi_mode.sv
// rtl/shift_register_multi_mode.sv - parametrised multi-mode shift register / delay line
//
// Purpose: DEPTH stages of DATA_W bits supporting shift left/right, rotate
// left/right and parallel load, with a saturating fill counter that marks
// when the word leaving the register carries valid data.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear, wins over en and mode
//   en          operation enable (0 = hold)
//   mode        0 hold, 1 shl, 2 shr, 3 rotl, 4 rotr, 5 load, 6/7 hold
//   din         serial input word
//   pload       parallel load, stage k = pload[k*DATA_W +: DATA_W]
//   dout        word ejected or wrapped by the last shift/rotate
//   dout_valid  one-cycle pulse, dout holds a valid word
//   pout        all stages, same packing as pload
//   fill_cnt    number of valid stages, 0..DEPTH
//   full        fill_cnt == DEPTH

module shift_register_multi_mode #(
   parameter int DATA_W = 1,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic [2:0]              mode,
   input  logic [DATA_W-1:0]       din,
   input  logic [DEPTH*DATA_W-1:0] pload,
   output logic [DATA_W-1:0]       dout,
   output logic                    dout_valid,
   output logic [DEPTH*DATA_W-1:0] pout,
   output logic [CNT_W-1:0]        fill_cnt,
   output logic                    full
);

   localparam logic [2:0] MODE_SHL  = 3'd1;
   localparam logic [2:0] MODE_SHR  = 3'd2;
   localparam logic [2:0] MODE_ROTL = 3'd3;
   localparam logic [2:0] MODE_ROTR = 3'd4;
   localparam logic [2:0] MODE_LOAD = 3'd5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Packed so that stage k occupies bits [k*DATA_W +: DATA_W] of the flat view.
   logic [DEPTH-1:0][DATA_W-1:0] stages;

   assign pout = stages;
   assign full = (fill_cnt == CNT_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         fill_cnt   <= '0;
      end else if (clr) begin
         stages     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         fill_cnt   <= '0;
      end else begin
         dout_valid <= 1'b0;
         if (en) begin
            case (mode)
               MODE_SHL: begin
                  stages     <= {stages[DEPTH-2:0], din};
                  dout       <= stages[DEPTH-1];
                  // The ejected word is only meaningful once every stage holds data.
                  dout_valid <= full;
                  if (!full) fill_cnt <= fill_cnt + CNT_ONE;
               end
               MODE_SHR: begin
                  stages     <= {din, stages[DEPTH-1:1]};
                  dout       <= stages[0];
                  dout_valid <= full;
                  if (!full) fill_cnt <= fill_cnt + CNT_ONE;
               end
               MODE_ROTL: begin
                  stages     <= {stages[DEPTH-2:0], stages[DEPTH-1]};
                  dout       <= stages[DEPTH-1];
                  dout_valid <= full;
               end
               MODE_ROTR: begin
                  stages     <= {stages[0], stages[DEPTH-1:1]};
                  dout       <= stages[0];
                  dout_valid <= full;
               end
               MODE_LOAD: begin
                  stages   <= pload;
                  fill_cnt <= CNT_FULL;
               end
               default: begin
                  // hold and reserved modes: state kept, dout_valid already cleared
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_register_multi_mode.sv
// tb/tb_shift_register_multi_mode.sv - self-checking bench for shift_register_multi_mode

module tb_shift_register_multi_mode;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int BD = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // small instance
   logic           clr = 1'b0, en = 1'b0;
   logic [2:0]     mode = 3'd0;
   logic [W-1:0]   din = '0;
   logic [D*W-1:0] pload = '0;
   logic [W-1:0]   dout;
   logic           dout_valid;
   logic [D*W-1:0] pout;
   logic [2:0]     fill_cnt;
   logic           full;

   // legacy SISO instance
   logic           b_clr = 1'b0, b_en = 1'b0;
   logic [2:0]     b_mode = 3'd0;
   logic [0:0]     b_din = '0;
   logic [BD-1:0]  b_pload = '0;
   logic [0:0]     b_dout;
   logic           b_dout_valid;
   logic [BD-1:0]  b_pout;
   logic [8:0]     b_fill_cnt;
   logic           b_full;

   shift_register_multi_mode #(.DATA_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .din(din),
      .pload(pload), .dout(dout), .dout_valid(dout_valid), .pout(pout),
      .fill_cnt(fill_cnt), .full(full));

   shift_register_multi_mode #(.DATA_W(1), .DEPTH(BD)) dut_big (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .en(b_en), .mode(b_mode), .din(b_din),
      .pload(b_pload), .dout(b_dout), .dout_valid(b_dout_valid), .pout(b_pout),
      .fill_cnt(b_fill_cnt), .full(b_full));

   int checks = 0;
   int errors = 0;

   // Reference model: the register is a list of words indexed by stage number.
   logic [W-1:0] m_st[D];
   logic [W-1:0] m_dout;
   logic         m_valid;
   int           m_cnt;

   function automatic logic [D*W-1:0] model_pout();
      logic [D*W-1:0] r;
      for (int k = 0; k < D; k++) r[k*W +: W] = m_st[k];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < D; k++) m_st[k] = '0;
      m_dout = '0; m_valid = 1'b0; m_cnt = 0;
   endtask

   task automatic model_step(input logic c, input logic e, input logic [2:0] md,
                             input logic [W-1:0] d, input logic [D*W-1:0] pl);
      logic [W-1:0] nxt[D];
      if (c) begin
         model_reset();
         return;
      end
      if (!e || md == 3'd0 || md > 3'd5) begin
         m_valid = 1'b0;
         return;
      end
      if (md == 3'd5) begin
         for (int k = 0; k < D; k++) m_st[k] = pl[k*W +: W];
         m_cnt = D; m_valid = 1'b0;
         return;
      end
      m_valid = (m_cnt == D);
      if (md == 3'd1 || md == 3'd3) begin
         m_dout = m_st[D-1];
         for (int k = 1; k < D; k++) nxt[k] = m_st[k-1];
         nxt[0] = (md == 3'd1) ? d : m_st[D-1];
      end else begin
         m_dout = m_st[0];
         for (int k = 0; k < D-1; k++) nxt[k] = m_st[k+1];
         nxt[D-1] = (md == 3'd2) ? d : m_st[0];
      end
      for (int k = 0; k < D; k++) m_st[k] = nxt[k];
      if ((md == 3'd1 || md == 3'd2) && m_cnt < D) m_cnt++;
   endtask

   // Drive one operation across one rising edge and advance the model.
   task automatic apply(input logic c, input logic e, input logic [2:0] md,
                        input logic [W-1:0] d, input logic [D*W-1:0] pl);
      clr = c; en = e; mode = md; din = d; pload = pl;
      @(posedge clk);
      #1;
      model_step(c, e, md, d, pl);
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++;
      if (pout !== '0 || dout !== '0 || dout_valid !== 1'b0 || fill_cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_initial pout=%h dout=%h v=%b cnt=%0d required 0", pout, dout, dout_valid, fill_cnt);
      end
      rst_n = 1'b1;
      model_reset();
      apply(1'b0, 1'b1, 3'd5, 8'h00, 32'hAAAA_AAAA);
      checks++;
      if (pout !== 32'hAAAA_AAAA || fill_cnt !== 3'd4 || full !== 1'b1) begin
         errors++;
         $display("FAIL reset_load pout=%h cnt=%0d full=%b required aaaaaaaa 4 1", pout, fill_cnt, full);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pout !== '0 || dout !== '0 || dout_valid !== 1'b0 || fill_cnt !== 3'd0 || full !== 1'b0) begin
         errors++;
         $display("FAIL reset_async pout=%h dout=%h v=%b cnt=%0d required 0", pout, dout, dout_valid, fill_cnt);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_shl_fill();
      logic [2:0] exp_cnt[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b1, 3'd1, W'(i + 1), '0);
         checks++;
         if (fill_cnt !== exp_cnt[i] || dout_valid !== (i == 4)) begin
            errors++;
            $display("FAIL shl_fill_%0d cnt=%0d v=%b required %0d %b", i, fill_cnt, dout_valid, exp_cnt[i], i == 4);
         end
      end
      checks++;
      if (dout !== 8'h01 || pout !== 32'h0203_0405) begin
         errors++;
         $display("FAIL shl_final dout=%h pout=%h required 01 02030405", dout, pout);
      end
   endtask

   task automatic test_load_rotr();
      logic [W-1:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      apply(1'b1, 1'b0, 3'd0, '0, '0);
      apply(1'b0, 1'b1, 3'd5, '0, 32'h4433_2211);
      checks++;
      if (dout_valid !== 1'b0 || dout !== 8'h00 || fill_cnt !== 3'd4) begin
         errors++;
         $display("FAIL load_state dout=%h v=%b cnt=%0d required 00 0 4", dout, dout_valid, fill_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b1, 3'd4, 8'hEE, '0);
         checks++;
         if (dout !== exp_d[i] || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL rotr_%0d dout=%h v=%b required %h 1", i, dout, dout_valid, exp_d[i]);
         end
      end
      checks++;
      if (pout !== 32'h4433_2211 || fill_cnt !== 3'd4) begin
         errors++;
         $display("FAIL rotr_final pout=%h cnt=%0d required 44332211 4", pout, fill_cnt);
      end
   endtask

   task automatic test_hold_clr();
      logic [D*W-1:0] snap;
      apply(1'b1, 1'b0, 3'd0, '0, '0);
      for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 3'd1, W'($urandom), '0);
      snap = pout;
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 3'd1, 8'h5A, '0);
         checks++;
         if (pout !== snap || pout !== model_pout() || fill_cnt !== 3'd4 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d pout=%h cnt=%0d v=%b required %h 4 0", i, pout, fill_cnt, dout_valid, model_pout());
         end
      end
      apply(1'b1, 1'b1, 3'd1, 8'h77, '0);
      checks++;
      if (pout !== '0 || fill_cnt !== 3'd0 || dout_valid !== 1'b0 || dout !== '0) begin
         errors++;
         $display("FAIL clr_priority pout=%h cnt=%0d v=%b dout=%h required 0", pout, fill_cnt, dout_valid, dout);
      end
   endtask

   task automatic test_reserved();
      logic [D*W-1:0] snap_p;
      logic [W-1:0]   snap_d;
      apply(1'b0, 1'b1, 3'd5, '0, 32'hDEAD_BEEF);
      apply(1'b0, 1'b1, 3'd3, '0, '0);
      snap_p = pout; snap_d = dout;
      for (int md = 6; md < 8; md++) begin
         apply(1'b0, 1'b1, 3'(md), 8'hC3, 32'h1234_5678);
         checks++;
         if (pout !== snap_p || dout !== snap_d || fill_cnt !== 3'd4 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reserved_%0d pout=%h dout=%h cnt=%0d v=%b required %h %h 4 0", md, pout, dout, fill_cnt, dout_valid, snap_p, snap_d);
         end
      end
   endtask

   task automatic test_random();
      logic c, e;
      logic [2:0] md;
      apply(1'b1, 1'b0, 3'd0, '0, '0);
      for (int i = 0; i < 300; i++) begin
         c  = ($urandom_range(0, 19) == 0);
         e  = ($urandom_range(0, 5) != 0);
         md = 3'($urandom_range(0, 7));
         if (md == 3'd5 && $urandom_range(0, 2) != 0) md = 3'($urandom_range(1, 2));
         apply(c, e, md, W'($urandom), D*W'({$urandom}));
         checks++;
         if (pout !== model_pout() || dout !== m_dout || dout_valid !== m_valid ||
             fill_cnt !== 3'(m_cnt) || full !== (m_cnt == D)) begin
            errors++;
            $display("FAIL random_%0d pout=%h dout=%h v=%b cnt=%0d required %h %h %b %0d",
                     i, pout, dout, dout_valid, fill_cnt, model_pout(), m_dout, m_valid, m_cnt);
         end
      end
   endtask

   task automatic test_legacy_siso();
      int early = 0;
      b_clr = 1'b1; b_en = 1'b0;
      @(posedge clk); #1;
      b_clr = 1'b0; b_en = 1'b1; b_mode = 3'd2;
      for (int edge_n = 1; edge_n <= BD + 1; edge_n++) begin
         b_din = (edge_n == 1) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         if (edge_n <= BD && (b_dout_valid !== 1'b0 || b_dout !== 1'b0)) early++;
      end
      b_en = 1'b0;
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL legacy_early dout/valid nonzero on %0d edges required 0", early);
      end
      checks++;
      if (b_dout !== 1'b1 || b_dout_valid !== 1'b1 || b_fill_cnt !== 9'd256 || b_full !== 1'b1) begin
         errors++;
         $display("FAIL legacy_257 dout=%b v=%b cnt=%0d full=%b required 1 1 256 1", b_dout, b_dout_valid, b_fill_cnt, b_full);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_shl_fill();
      test_load_rotr();
      test_hold_clr();
      test_reserved();
      test_random();
      test_legacy_siso();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
